// File: rtl/mips_multicycle_control_if.sv
// Control bus between the multicycle MIPS main control FSM and its datapath.
// The master side is the control FSM. It receives the opcode and the memory
// ready strobe, and it drives every select, enable and debug signal.
//
// Handshake: the FSM holds a memory request (mem_read or mem_write) steady
// until memory returns mem_ready=1 in the same cycle. That cycle completes the
// access. The cycles before it are wait cycles, and no write enable is
// asserted during them.
interface mips_multicycle_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       illegal_op;
  logic       instr_retire;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, instr_retire, state
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, instr_retire, state
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS32 datapath.
// It steps every instruction through fetch, decode, execute, memory and
// writeback states. The outputs are a combinational decode of the state, and
// some of them are gated by mem_ready.
// Optional feature macro: MC_ADDI_EN adds support for addi through the
// ADDI_EX and ADDI_WB states. Without it, opcode 001000 is reported as illegal.
module mips_multicycle_control (
  input logic                           clk,
  input logic                           rst,
  mips_multicycle_control_if.master     bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADDR  = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t r_state;
  state_t w_next_state;

  logic       w_pc_write, w_pc_write_cond, w_i_or_d, w_mem_read, w_mem_write;
  logic       w_ir_write, w_mem_to_reg, w_reg_dst, w_reg_write, w_alu_src_a;
  logic [1:0] w_alu_src_b, w_alu_op, w_pc_source;
  logic       w_illegal_op, w_instr_retire;
  logic [3:0] w_state;

  // State register: synchronous reset returns the FSM to FETCH.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next_state;
  end

  // Next-state logic. Opcode matters only in DECODE and MEMADDR.
  // The memory states stay put until mem_ready arrives.
  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH:    w_next_state = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:      w_next_state = S_RTYPE_EX;
          OP_LW, OP_SW:  w_next_state = S_MEMADDR;
          OP_BEQ:        w_next_state = S_BRANCH;
          OP_J:          w_next_state = S_JUMP;
`ifdef MC_ADDI_EN
          OP_ADDI:       w_next_state = S_ADDI_EX;
`endif
          default:       w_next_state = S_FETCH;
        endcase
      end
      S_MEMADDR:  w_next_state = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    w_next_state = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:    w_next_state = S_FETCH;
      S_MEMWR:    w_next_state = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPE_EX: w_next_state = S_RTYPE_WB;
      S_RTYPE_WB: w_next_state = S_FETCH;
      S_BRANCH:   w_next_state = S_FETCH;
      S_JUMP:     w_next_state = S_FETCH;
`ifdef MC_ADDI_EN
      S_ADDI_EX:  w_next_state = S_ADDI_WB;
      S_ADDI_WB:  w_next_state = S_FETCH;
`endif
      default:    w_next_state = S_FETCH;
    endcase
  end

  // Output decode of the current state. While rst is high every output,
  // including the debug state, is forced to zero.
  always_comb begin
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_i_or_d        = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_ir_write      = 1'b0;
    w_mem_to_reg    = 1'b0;
    w_reg_dst       = 1'b0;
    w_reg_write     = 1'b0;
    w_alu_src_a     = 1'b0;
    w_alu_src_b     = 2'b00;
    w_alu_op        = 2'b00;
    w_pc_source     = 2'b00;
    w_illegal_op    = 1'b0;
    w_instr_retire  = 1'b0;
    w_state         = 4'd0;
    if (!rst) begin
      w_state = r_state;
      case (r_state)
        S_FETCH: begin
          w_mem_read  = 1'b1;
          w_alu_src_b = 2'b01;
          w_ir_write  = bus.mem_ready;
          w_pc_write  = bus.mem_ready;
        end
        S_DECODE: begin
          w_alu_src_b = 2'b11;
          if (w_next_state == S_FETCH) begin
            w_illegal_op   = 1'b1;
            w_instr_retire = 1'b1;
          end
        end
        S_MEMADDR: begin
          w_alu_src_a = 1'b1;
          w_alu_src_b = 2'b10;
        end
        S_MEMRD: begin
          w_mem_read = 1'b1;
          w_i_or_d   = 1'b1;
        end
        S_MEMWB: begin
          w_reg_write    = 1'b1;
          w_mem_to_reg   = 1'b1;
          w_instr_retire = 1'b1;
        end
        S_MEMWR: begin
          w_mem_write    = 1'b1;
          w_i_or_d       = 1'b1;
          w_instr_retire = bus.mem_ready;
        end
        S_RTYPE_EX: begin
          w_alu_src_a = 1'b1;
          w_alu_op    = 2'b10;
        end
        S_RTYPE_WB: begin
          w_reg_write    = 1'b1;
          w_reg_dst      = 1'b1;
          w_instr_retire = 1'b1;
        end
        S_BRANCH: begin
          w_alu_src_a     = 1'b1;
          w_alu_op        = 2'b01;
          w_pc_write_cond = 1'b1;
          w_pc_source     = 2'b01;
          w_instr_retire  = 1'b1;
        end
        S_JUMP: begin
          w_pc_write     = 1'b1;
          w_pc_source    = 2'b10;
          w_instr_retire = 1'b1;
        end
`ifdef MC_ADDI_EN
        S_ADDI_EX: begin
          w_alu_src_a = 1'b1;
          w_alu_src_b = 2'b10;
        end
        S_ADDI_WB: begin
          w_reg_write    = 1'b1;
          w_instr_retire = 1'b1;
        end
`endif
        default: begin
          w_state = r_state;
        end
      endcase
    end
  end

  assign bus.pc_write      = w_pc_write;
  assign bus.pc_write_cond = w_pc_write_cond;
  assign bus.i_or_d        = w_i_or_d;
  assign bus.mem_read      = w_mem_read;
  assign bus.mem_write     = w_mem_write;
  assign bus.ir_write      = w_ir_write;
  assign bus.mem_to_reg    = w_mem_to_reg;
  assign bus.reg_dst       = w_reg_dst;
  assign bus.reg_write     = w_reg_write;
  assign bus.alu_src_a     = w_alu_src_a;
  assign bus.alu_src_b     = w_alu_src_b;
  assign bus.alu_op        = w_alu_op;
  assign bus.pc_source     = w_pc_source;
  assign bus.illegal_op    = w_illegal_op;
  assign bus.instr_retire  = w_instr_retire;
  assign bus.state         = w_state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Testbench for mips_multicycle_control.
// The reference model turns each instruction, together with its stall
// counts, into a list of expected output vectors, one per cycle, plus the
// inputs to drive in that cycle. The driver then plays the list back.
// Opcode bits change at random in the states where the FSM ignores them.
module tb_mips_multicycle_control;

  localparam int W = 22;

`ifdef MC_ADDI_EN
  localparam bit ADDI_EN = 1'b1;
`else
  localparam bit ADDI_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  mips_multicycle_control_if bus ();

  mips_multicycle_control dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and reset setup.
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] exp_q[$];
  logic [5:0]   opc_q[$];
  logic         mr_q[$];
  string        tag_q[$];

  // Scoreboard compare.
  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%06h exp=%06h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] observed();
    return {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
            bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
            bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
            bus.pc_source, bus.illegal_op, bus.instr_retire, bus.state};
  endfunction

  // Packs one expected cycle in the same field order as observed().
  function automatic logic [W-1:0] pk(
      input logic [3:0] st, input logic pcw, input logic pcwc, input logic iord,
      input logic mrd, input logic mwr, input logic irw, input logic m2r,
      input logic rdst, input logic rw, input logic srca, input logic [1:0] srcb,
      input logic [1:0] aop, input logic [1:0] psrc, input logic ill,
      input logic ret);
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aop,
            psrc, ill, ret, st};
  endfunction

  function automatic logic [5:0] rnd_opc();
    return 6'($urandom);
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom);
  endfunction

  task automatic push(input string tag, input logic [5:0] opc, input logic mr,
                      input logic [W-1:0] e);
    tag_q.push_back(tag);
    opc_q.push_back(opc);
    mr_q.push_back(mr);
    exp_q.push_back(e);
  endtask

  // Reference model: expands one instruction into its cycles. fs is the
  // number of FETCH wait cycles; ms is the number of data-memory wait cycles.
  task automatic model_instr(input logic [5:0] opc, input int fs, input int ms);
    logic legal;
    logic mr;
    for (int k = 0; k <= fs; k++) begin
      mr = (k == fs);
      push("fetch", rnd_opc(), mr,
           pk(4'd0, mr, 0, 0, 1, 0, mr, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0));
    end
    legal = (opc == 6'd0) || (opc == 6'd35) || (opc == 6'd43) ||
            (opc == 6'd4) || (opc == 6'd2) || (ADDI_EN && opc == 6'd8);
    push("decode", opc, rnd_bit(),
         pk(4'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, !legal, !legal));
    if (legal) begin
      case (opc)
        6'd0: begin
          push("rtype_ex", rnd_opc(), rnd_bit(),
               pk(4'd6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0, 0));
          push("rtype_wb", rnd_opc(), rnd_bit(),
               pk(4'd7, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 1));
        end
        6'd35, 6'd43: begin
          push("memaddr", opc, rnd_bit(),
               pk(4'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0));
          for (int k = 0; k <= ms; k++) begin
            mr = (k == ms);
            if (opc == 6'd35)
              push("memrd", rnd_opc(), mr,
                   pk(4'd3, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
            else
              push("memwr", rnd_opc(), mr,
                   pk(4'd5, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, mr));
          end
          if (opc == 6'd35)
            push("memwb", rnd_opc(), rnd_bit(),
                 pk(4'd4, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 1));
        end
        6'd4:
          push("branch", rnd_opc(), rnd_bit(),
               pk(4'd8, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0, 1));
        6'd2:
          push("jump", rnd_opc(), rnd_bit(),
               pk(4'd9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 0, 1));
        default: begin
          push("addi_ex", rnd_opc(), rnd_bit(),
               pk(4'd10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0));
          push("addi_wb", rnd_opc(), rnd_bit(),
               pk(4'd11, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 1));
        end
      endcase
    end
  endtask

  // Driver for one cycle: apply the inputs away from the rising edge, let the
  // combinational outputs settle, then compare.
  task automatic step(input string tag, input logic [5:0] opc, input logic mr,
                      input logic rstv, input logic [W-1:0] e);
    @(negedge clk);
    rst = rstv;
    bus.opcode = opc;
    bus.mem_ready = mr;
    #1;
    chk(tag, observed(), e);
  endtask

  task automatic drain();
    while (exp_q.size() > 0) begin
      step(tag_q.pop_front(), opc_q.pop_front(), mr_q.pop_front(), 1'b0,
           exp_q.pop_front());
    end
  endtask

  initial begin
    logic [5:0] op;
    int sel;
    bus.opcode = 6'd0;
    bus.mem_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    step("reset0", rnd_opc(), 1'b1, 1'b1, '0);
    step("reset1", rnd_opc(), 1'b1, 1'b1, '0);

    // Directed instructions from the test plan.
    model_instr(6'b000000, 0, 0);   // R-type
    model_instr(6'b100011, 3, 0);   // lw with fetch stall
    model_instr(6'b101011, 0, 2);   // sw with write stall
    model_instr(6'b000100, 0, 0);   // beq
    model_instr(6'b000010, 0, 0);   // j
    model_instr(6'b111111, 0, 0);   // illegal
    model_instr(6'b001000, 0, 0);   // addi, legal only with MC_ADDI_EN
    drain();

    // Reset while MEMRD is waiting on memory.
    model_instr(6'b100011, 0, 0);
    void'(exp_q.pop_back());
    void'(opc_q.pop_back());
    void'(mr_q.pop_back());
    void'(tag_q.pop_back());
    void'(exp_q.pop_back());
    void'(opc_q.pop_back());
    void'(mr_q.pop_back());
    void'(tag_q.pop_back());
    push("memrd_wait", rnd_opc(), 1'b0,
         pk(4'd3, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
    drain();
    step("rst_memrd", rnd_opc(), 1'b1, 1'b1, '0);
    model_instr(6'b000010, 0, 0);
    drain();

    // Randomized instruction stream.
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0: op = 6'd0;
        1: op = 6'd35;
        2: op = 6'd43;
        3: op = 6'd4;
        4: op = 6'd2;
        5: op = 6'd8;
        default: op = rnd_opc();
      endcase
      model_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
